cam_ctrl: RTL and testbench

// Request sequencer in front of the CAM decoder/array. Accepts one op at a time
// (READ, WRITE, SEARCH, INVALIDATE) on a valid/ready port and drives the decoder's

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_prio_enc.sv | 26 ++
 rtl/cam_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default sizes for the CAM request sequencer.
package cam_pkg;

  localparam int unsigned CAM_WIDTH      = 32;
  localparam int unsigned CAM_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_SEARCH = 2'd2,
    OP_INVAL  = 2'd3
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over a match vector, with a multi-hit flag.
module cam_prio_enc #(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] match_i,
  output logic             hit_o,
  output logic             multi_o,
  output logic [IW-1:0]    index_o
);

  // Scan high to low so the lowest set bit is the last one to claim the index.
  always_comb begin
    hit_o   = 1'b0;
    multi_o = 1'b0;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        if (hit_o) multi_o = 1'b1;
        hit_o   = 1'b1;
        index_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// Request sequencer for the CAM: one op in flight, strobes decoder, tracks valid bits.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned WIDTH      = CAM_WIDTH,
  parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH,
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH,
  localparam int unsigned CW        = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  input  logic [WIDTH-1:0]      req_data_i,
  output logic                  read_enable_o,
  output logic [ADDR_WIDTH-1:0] read_index_o,
  output logic                  write_enable_o,
  output logic [ADDR_WIDTH-1:0] write_index_o,
  output logic                  search_enable_o,
  output logic [WIDTH-1:0]      cam_data_o,
  input  logic [WIDTH-1:0]      read_data_i,
  input  logic [DEPTH-1:0]      match_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [1:0]            resp_op_o,
  output logic                  resp_hit_o,
  output logic                  resp_multi_o,
  output logic [ADDR_WIDTH-1:0] resp_index_o,
  output logic [WIDTH-1:0]      resp_data_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o
);

  cam_state_e            state_q, state_n;
  cam_op_e               op_q, op_n;
  logic [ADDR_WIDTH-1:0] index_q, index_n;
  logic [DEPTH-1:0]      valid_q, valid_n;
  logic [CW-1:0]         count_n;
  logic                  full_n, ready_n;

  logic                  rd_en_n, wr_en_n, sr_en_n;
  logic [ADDR_WIDTH-1:0] rd_idx_n, wr_idx_n;
  logic [WIDTH-1:0]      cam_data_n;

  logic                  resp_valid_n, hit_n, multi_n;
  logic [1:0]            resp_op_n;
  logic [ADDR_WIDTH-1:0] resp_index_n;
  logic [WIDTH-1:0]      resp_data_n;

  logic [DEPTH-1:0]      search_vec;
  logic                  enc_hit, enc_multi;
  logic [ADDR_WIDTH-1:0] enc_index;

  // Stale entries must never report a search hit.
  assign search_vec = match_i & valid_q;

  cam_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
    .match_i (search_vec),
    .hit_o   (enc_hit),
    .multi_o (enc_multi),
    .index_o (enc_index)
  );

  // State, request context, decoder strobes, response and occupancy registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_READ;
      index_q         <= '0;
      valid_q         <= '0;
      count_o         <= '0;
      full_o          <= 1'b0;
      req_ready_o     <= 1'b1;
      read_enable_o   <= 1'b0;
      read_index_o    <= '0;
      write_enable_o  <= 1'b0;
      write_index_o   <= '0;
      search_enable_o <= 1'b0;
      cam_data_o      <= '0;
      resp_valid_o    <= 1'b0;
      resp_op_o       <= '0;
      resp_hit_o      <= 1'b0;
      resp_multi_o    <= 1'b0;
      resp_index_o    <= '0;
      resp_data_o     <= '0;
    end else begin
      state_q         <= state_n;
      op_q            <= op_n;
      index_q         <= index_n;
      valid_q         <= valid_n;
      count_o         <= count_n;
      full_o          <= full_n;
      req_ready_o     <= ready_n;
      read_enable_o   <= rd_en_n;
      read_index_o    <= rd_idx_n;
      write_enable_o  <= wr_en_n;
      write_index_o   <= wr_idx_n;
      search_enable_o <= sr_en_n;
      cam_data_o      <= cam_data_n;
      resp_valid_o    <= resp_valid_n;
      resp_op_o       <= resp_op_n;
      resp_hit_o      <= hit_n;
      resp_multi_o    <= multi_n;
      resp_index_o    <= resp_index_n;
      resp_data_o     <= resp_data_n;
    end
  end

  // Next-state and next-output logic; strobes and decoder fields are only live in ISSUE.
  always_comb begin
    state_n      = state_q;
    op_n         = op_q;
    index_n      = index_q;
    valid_n      = valid_q;
    count_n      = count_o;
    rd_en_n      = 1'b0;
    wr_en_n      = 1'b0;
    sr_en_n      = 1'b0;
    rd_idx_n     = '0;
    wr_idx_n     = '0;
    cam_data_n   = '0;
    resp_valid_n = resp_valid_o;
    resp_op_n    = resp_op_o;
    hit_n        = resp_hit_o;
    multi_n      = resp_multi_o;
    resp_index_n = resp_index_o;
    resp_data_n  = resp_data_o;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_n    = cam_op_e'(req_op_i);
          index_n = req_index_i;
          case (cam_op_e'(req_op_i))
            OP_READ: begin
              state_n  = ST_ISSUE;
              rd_en_n  = 1'b1;
              rd_idx_n = req_index_i;
            end
            OP_WRITE: begin
              state_n    = ST_ISSUE;
              wr_en_n    = 1'b1;
              wr_idx_n   = req_index_i;
              cam_data_n = req_data_i;
            end
            OP_SEARCH: begin
              state_n    = ST_ISSUE;
              sr_en_n    = 1'b1;
              cam_data_n = req_data_i;
            end
            default: begin
              // Invalidate needs no array access; answer straight away.
              state_n = ST_RESP;
              if (valid_q[req_index_i]) count_n = count_o - CW'(1);
              valid_n[req_index_i] = 1'b0;
              resp_valid_n = 1'b1;
              resp_op_n    = req_op_i;
              hit_n        = 1'b0;
              multi_n      = 1'b0;
              resp_index_n = req_index_i;
              resp_data_n  = '0;
            end
          endcase
        end
      end

      ST_ISSUE: begin
        if (op_q == OP_WRITE) begin
          state_n = ST_RESP;
          if (!valid_q[index_q]) count_n = count_o + CW'(1);
          valid_n[index_q] = 1'b1;
          resp_valid_n = 1'b1;
          resp_op_n    = op_q;
          hit_n        = 1'b0;
          multi_n      = 1'b0;
          resp_index_n = index_q;
          resp_data_n  = '0;
        end else begin
          state_n = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        state_n      = ST_RESP;
        resp_valid_n = 1'b1;
        resp_op_n    = op_q;
        if (op_q == OP_SEARCH) begin
          hit_n        = enc_hit;
          multi_n      = enc_multi;
          resp_index_n = enc_index;
          resp_data_n  = '0;
        end else begin
          hit_n        = valid_q[index_q];
          multi_n      = 1'b0;
          resp_index_n = index_q;
          resp_data_n  = read_data_i;
        end
      end

      ST_RESP: begin
        if (resp_ready_i) begin
          state_n      = ST_IDLE;
          resp_valid_n = 1'b0;
          resp_op_n    = '0;
          hit_n        = 1'b0;
          multi_n      = 1'b0;
          resp_index_n = '0;
          resp_data_n  = '0;
        end
      end

      default: begin
        state_n      = ST_IDLE;
        resp_valid_n = 1'b0;
      end
    endcase

    full_n  = (count_n == CW'(DEPTH));
    ready_n = (state_n == ST_IDLE);
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed, table-driven bench for cam_ctrl with hand-computed expectations.
module tb_cam_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned D  = 32;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [1:0]    req_op_i;
  logic [AW-1:0] req_index_i;
  logic [W-1:0]  req_data_i;
  logic          read_enable_o;
  logic [AW-1:0] read_index_o;
  logic          write_enable_o;
  logic [AW-1:0] write_index_o;
  logic          search_enable_o;
  logic [W-1:0]  cam_data_o;
  logic [W-1:0]  read_data_i;
  logic [D-1:0]  match_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [1:0]    resp_op_o;
  logic          resp_hit_o;
  logic          resp_multi_o;
  logic [AW-1:0] resp_index_o;
  logic [W-1:0]  resp_data_o;
  logic [AW:0]   count_o;
  logic          full_o;

  int checks   = 0;
  int failures = 0;

  cam_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_index_i(req_index_i), .req_data_i(req_data_i),
    .read_enable_o(read_enable_o), .read_index_o(read_index_o),
    .write_enable_o(write_enable_o), .write_index_o(write_index_o),
    .search_enable_o(search_enable_o), .cam_data_o(cam_data_o),
    .read_data_i(read_data_i), .match_i(match_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_op_o(resp_op_o), .resp_hit_o(resp_hit_o), .resp_multi_o(resp_multi_o),
    .resp_index_o(resp_index_o), .resp_data_o(resp_data_o),
    .count_o(count_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] match;
    logic [31:0] rdata;
    logic        e_hit;
    logic        e_multi;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    logic [5:0]  e_count;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, track strobes until the response, optionally stall, then consume it.
  task automatic run_op(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data,
                        input logic [31:0] match, input logic [31:0] rdata,
                        input logic e_hit, input logic e_multi, input logic [4:0] e_idx,
                        input logic [31:0] e_data, input logic [5:0] e_count,
                        input int hold, input string name);
    int lat, n_rd, n_wr, n_sr, e_lat;
    logic ok;
    @(negedge clk_i);
    chk({name, " req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_op_i = op; req_index_i = idx; req_data_i = data;
    match_i = match; read_data_i = rdata;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = 0; n_rd = 0; n_wr = 0; n_sr = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (read_enable_o) begin
        n_rd++;
        chk({name, " read_index"}, 64'(read_index_o), 64'(idx));
      end
      if (write_enable_o) begin
        n_wr++;
        chk({name, " write_index"}, 64'(write_index_o), 64'(idx));
        chk({name, " write_data"}, 64'(cam_data_o), 64'(data));
      end
      if (search_enable_o) begin
        n_sr++;
        chk({name, " search_key"}, 64'(cam_data_o), 64'(data));
      end
    end while (!resp_valid_o && lat < 8);
    e_lat = (op == 2'd3) ? 1 : (op == 2'd1) ? 2 : 3;
    chk({name, " latency"}, 64'(lat), 64'(e_lat));
    chk({name, " rd_strobes"}, 64'(n_rd), 64'((op == 2'd0) ? 1 : 0));
    chk({name, " wr_strobes"}, 64'(n_wr), 64'((op == 2'd1) ? 1 : 0));
    chk({name, " sr_strobes"}, 64'(n_sr), 64'((op == 2'd2) ? 1 : 0));
    chk({name, " resp_op"}, 64'(resp_op_o), 64'(op));
    chk({name, " resp_hit"}, 64'(resp_hit_o), 64'(e_hit));
    chk({name, " resp_multi"}, 64'(resp_multi_o), 64'(e_multi));
    chk({name, " resp_index"}, 64'(resp_index_o), 64'(e_idx));
    chk({name, " resp_data"}, 64'(resp_data_o), 64'(e_data));
    chk({name, " count"}, 64'(count_o), 64'(e_count));
    chk({name, " full"}, 64'(full_o), 64'(e_count == 6'd32));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      ok = resp_valid_o && !req_ready_o && !read_enable_o && !write_enable_o &&
           !search_enable_o && resp_hit_o == e_hit && resp_multi_o == e_multi &&
           resp_index_o == e_idx && resp_data_o == e_data && resp_op_o == op &&
           count_o == e_count;
      chk({name, " hold_stable"}, 64'(ok), 64'd1);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    @(negedge clk_i);
    chk({name, " resp_done"}, 64'(resp_valid_o), 64'd0);
    chk({name, " ready_again"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int exp_cnt;
    reset_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_index_i = '0;
    req_data_i = '0; read_data_i = '0; match_i = '0; resp_ready_i = 1'b0;

    vecs[0] = '{2'd1, 5'd3, 32'hDEADBEEF, 32'h0, 32'h0,        1'b0, 1'b0, 5'd3, 32'h0,        6'd1};
    vecs[1] = '{2'd0, 5'd3, 32'h0,        32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 6'd1};
    vecs[2] = '{2'd0, 5'd4, 32'h0,        32'h0, 32'h12345678, 1'b0, 1'b0, 5'd4, 32'h12345678, 6'd1};
    vecs[3] = '{2'd1, 5'd5, 32'hA5A5A5A5, 32'h0, 32'h0,        1'b0, 1'b0, 5'd5, 32'h0,        6'd2};
    vecs[4] = '{2'd2, 5'd0, 32'hCAFEF00D, 32'h28, 32'h0,       1'b1, 1'b1, 5'd3, 32'h0,        6'd2};
    vecs[5] = '{2'd3, 5'd3, 32'h0,        32'h0, 32'h0,        1'b0, 1'b0, 5'd3, 32'h0,        6'd1};
    vecs[6] = '{2'd2, 5'd0, 32'hCAFEF00D, 32'h28, 32'h0,       1'b1, 1'b0, 5'd5, 32'h0,        6'd1};
    vecs[7] = '{2'd2, 5'd0, 32'h11111111, 32'h18, 32'h0,       1'b0, 1'b0, 5'd0, 32'h0,        6'd1};
    vecs[8] = '{2'd3, 5'd3, 32'h0,        32'h0, 32'h0,        1'b0, 1'b0, 5'd3, 32'h0,        6'd1};
    vecs[9] = '{2'd1, 5'd5, 32'h5A5A5A5A, 32'h0, 32'h0,        1'b0, 1'b0, 5'd5, 32'h0,        6'd1};

    // Reset values.
    #2;
    chk("rst req_ready", 64'(req_ready_o), 64'd1);
    chk("rst count", 64'(count_o), 64'd0);
    chk("rst strobes", 64'({read_enable_o, write_enable_o, search_enable_o}), 64'd0);
    chk("rst resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst full", 64'(full_o), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].idx, vecs[i].data, vecs[i].match, vecs[i].rdata,
             vecs[i].e_hit, vecs[i].e_multi, vecs[i].e_idx, vecs[i].e_data,
             vecs[i].e_count, 0, $sformatf("vec%0d", i));

    // Fill: only entry 5 is valid beforehand, so writing i adds one unless i == 5.
    for (int i = 0; i < 32; i++) begin
      exp_cnt = (i < 5) ? i + 2 : i + 1;
      run_op(2'd1, 5'(i), 32'(i) * 32'h01010101, 32'h0, 32'h0, 1'b0, 1'b0, 5'(i),
             32'h0, 6'(exp_cnt), 0, $sformatf("fill%0d", i));
    end
    run_op(2'd1, 5'd0, 32'h0BADC0DE, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 6'd32, 0, "rewrite0");
    run_op(2'd3, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 6'd31, 0, "inval0_a");
    run_op(2'd3, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 6'd31, 0, "inval0_b");

    // Response stall: entry 0 is invalid so lowest valid match is 1.
    run_op(2'd2, 5'd0, 32'hFEEDFACE, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 5'd1, 32'h0, 6'd31, 10,
           "hold_search");

    // Reset in the middle of a SEARCH issue cycle.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = 2'd2; req_data_i = 32'h0; match_i = 32'hFFFFFFFF;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("midrst issue_strobe", 64'(search_enable_o), 64'd1);
    reset_i = 1'b1;
    #1;
    chk("midrst strobe_drop", 64'(search_enable_o), 64'd0);
    chk("midrst resp_valid", 64'(resp_valid_o), 64'd0);
    chk("midrst count", 64'(count_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("midrst req_ready", 64'(req_ready_o), 64'd1);
    run_op(2'd0, 5'd3, 32'h0, 32'h0, 32'h77777777, 1'b0, 1'b0, 5'd3, 32'h77777777, 6'd0, 0,
           "post_rst_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a stuck design still produces the summary.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
